// File: rtl/dmem_if.sv
// dmem_if: request/response bundle between the CPU data port and dmem_responder.
interface dmem_if;
  logic        req;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [3:0]  be;
  logic [31:0] rdata;
  logic        ready;
  logic        err;
  logic        busy;
  modport master (output req, we, addr, wdata, be, input rdata, ready, err, busy);
  modport slave  (input req, we, addr, wdata, be, output rdata, ready, err, busy);
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated, handshaked 1K-word data memory with a one-cycle ready pulse.
// rst is active-low and asynchronous; the whole array is cleared on reset.
module dmem_responder #(
  parameter int WAIT_CYCLES = 2,
  parameter int DEPTH_LOG2  = 10,
  parameter int CHECK_RANGE = 1
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t r_state, w_next;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [31:0] r_addr, r_wdata, r_rdata;
  logic [3:0]  r_be;
  logic        r_err;
  logic [31:0] r_mem [0:(1<<DEPTH_LOG2)-1];
  logic [DEPTH_LOG2-1:0] w_idx;
  logic w_err, w_access, w_accept;
  assign w_idx    = r_addr[DEPTH_LOG2+1:2];
  assign w_err    = (r_addr[1:0] != 2'b00) || ((CHECK_RANGE != 0) && (|r_addr[31:DEPTH_LOG2+2]));
  assign w_access = (r_state == WAIT) && (r_cnt == 4'd0);
  assign w_accept = (r_state == IDLE) && bus.req;
  always_ff @(posedge clk or negedge rst)
    if (!rst) r_state <= IDLE;
    else      r_state <= w_next;
  always_comb
    w_next = r_state == IDLE ? (bus.req ? WAIT : IDLE) :
             r_state == WAIT ? (r_cnt == 4'd0 ? RESP : WAIT) : IDLE;
  always_comb begin
    bus.ready = r_state == RESP;
    bus.busy  = r_state != IDLE;
    bus.rdata = r_rdata;
    bus.err   = r_err;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_cnt   <= 4'(WAIT_CYCLES);
        r_we    <= bus.we;
        r_addr  <= bus.addr;
        r_wdata <= bus.wdata;
        r_be    <= bus.be;
      end else if (r_state == WAIT && r_cnt != 4'd0)
        r_cnt <= r_cnt - 4'd1;
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_err || r_we) ? 32'd0 : r_mem[w_idx];
      end
    end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i < (1<<DEPTH_LOG2); i++) r_mem[i] <= 32'd0;
    end else if (w_access && r_we && !w_err) begin
      for (int i = 0; i < 4; i++)
        if (r_be[i]) r_mem[w_idx][8*i +: 8] <= r_wdata[8*i +: 8];
    end
endmodule
